vectored_int_ctrl: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 19 +
 rtl/int_ack_sync.sv | 27 ++
 rtl/vectored_int_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_vectored_int_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared register map and FSM encoding for the vectored interrupt controller.
package int_ctrl_pkg;

    localparam logic [3:0] ADDR_IER = 4'h0;
    localparam logic [3:0] ADDR_IMR = 4'h1;
    localparam logic [3:0] ADDR_ITR = 4'h2;
    localparam logic [3:0] ADDR_IPR = 4'h3;
    localparam logic [3:0] ADDR_INR = 4'h4;
    localparam logic [3:0] ADDR_ISR = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_CLEAR    = 3'd4
    } intState_t;

endpackage

// File: rtl/int_ack_sync.sv
// Synchronizes the asynchronous toggle acknowledge and emits a one-cycle
// event for every level change seen on the synchronized signal.
module int_ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic AckIn,
    output logic AckEvent
);

    logic [STAGES-1:0] syncChain;
    logic              syncLast;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            syncChain <= '0;
            syncLast  <= 1'b0;
            AckEvent  <= 1'b0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], AckIn};
            syncLast  <= syncChain[STAGES-1];
            AckEvent  <= syncChain[STAGES-1] ^ syncLast;
        end
    end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Parametrised interrupt controller: mask/mode/pending registers, fixed-priority
// arbitration (urgent first, then lowest index) and a pulse/toggle-ack handshake.
module vectored_int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_IRQ         = 8,
    parameter  int unsigned ACK_SYNC_STAGES = 2,
    parameter  int unsigned ACK_TIMEOUT     = 0,
    localparam int unsigned ID_W            = $clog2(NUM_IRQ)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                WrEn,
    input  logic                BlockSelect,
    input  logic [3:0]          RegAddress,
    input  logic [31:0]         WrData,
    output logic [31:0]         RdData,
    input  logic                UrgentReq,
    input  logic [NUM_IRQ-1:0]  IntReq,
    output logic                K_IntReq,
    output logic                K_IntID,
    output logic [ID_W-1:0]     K_IntNum,
    input  logic                I_IntAck
);

    intState_t          state;
    intState_t          stateNext;
    logic               ier;
    logic [NUM_IRQ-1:0] imr;
    logic [NUM_IRQ-1:0] itr;
    logic [NUM_IRQ-1:0] pendEdge;
    logic [NUM_IRQ-1:0] intReqLast;
    logic               urgLast;
    logic               urgPend;
    logic [ID_W-1:0]    inr;
    logic               toSticky;
    logic [15:0]        waitCnt;
    logic               latchedEdge;
    logic               ackEvent;

    logic               regWr;
    logic [NUM_IRQ-1:0] ipr;
    logic [NUM_IRQ-1:0] reqMasked;
    logic               anyReq;
    logic               winValid;
    logic [ID_W-1:0]    winNum;
    logic               winEdge;
    logic               timeoutHit;
    logic [NUM_IRQ-1:0] edgeClr;
    logic               urgClr;
    logic               unusedWrData;

    assign unusedWrData = ^WrData;
    assign regWr        = WrEn & BlockSelect;
    assign ipr          = (itr & pendEdge) | (~itr & intReqLast);
    assign reqMasked    = ipr & imr;
    assign anyReq       = ier & (urgPend | (|reqMasked));
    assign urgClr       = (state == ST_CLEAR) && K_IntID;

    int_ack_sync #(
        .STAGES(ACK_SYNC_STAGES)
    ) u_ackSync (
        .Clock   (Clock),
        .Reset   (Reset),
        .AckIn   (I_IntAck),
        .AckEvent(ackEvent)
    );

    // Lowest-index masked pending line; descending scan lets low indices overwrite.
    always_comb begin
        winValid = 1'b0;
        winNum   = '0;
        winEdge  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (reqMasked[i]) begin
                winValid = 1'b1;
                winNum   = ID_W'(i);
                winEdge  = itr[i];
            end
        end
    end

    always_comb begin
        edgeClr = '0;
        if (regWr && (RegAddress == ADDR_IPR)) begin
            edgeClr = WrData[NUM_IRQ-1:0] & itr;
        end
        if ((state == ST_CLEAR) && !K_IntID && latchedEdge) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (ID_W'(i) == K_IntNum) begin
                    edgeClr[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateNext  = state;
        timeoutHit = 1'b0;
        case (state)
            ST_IDLE:     if (anyReq) stateNext = ST_ARB;
            ST_ARB:      stateNext = anyReq ? ST_REQ : ST_IDLE;
            ST_REQ:      stateNext = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ackEvent) begin
                    stateNext = ST_CLEAR;
                end else if ((ACK_TIMEOUT != 0) && (waitCnt == 16'(ACK_TIMEOUT))) begin
                    timeoutHit = 1'b1;
                    stateNext  = ST_IDLE;
                end
            end
            ST_CLEAR:    stateNext = ST_IDLE;
            default:     stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Pending capture: a new edge always wins over a same-cycle clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            intReqLast <= '0;
            pendEdge   <= '0;
            urgLast    <= 1'b0;
            urgPend    <= 1'b0;
        end else begin
            intReqLast <= IntReq;
            pendEdge   <= (pendEdge & ~edgeClr) | (IntReq & ~intReqLast & itr);
            urgLast    <= UrgentReq;
            urgPend    <= (urgPend & ~urgClr) | (UrgentReq & ~urgLast);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ier      <= 1'b0;
            imr      <= '0;
            itr      <= '0;
            toSticky <= 1'b0;
        end else begin
            if (regWr && (RegAddress == ADDR_IER)) ier <= WrData[0];
            if (regWr && (RegAddress == ADDR_IMR)) imr <= WrData[NUM_IRQ-1:0];
            if (regWr && (RegAddress == ADDR_ITR)) itr <= WrData[NUM_IRQ-1:0];
            if (timeoutHit) begin
                toSticky <= 1'b1;
            end else if (regWr && (RegAddress == ADDR_ISR) && WrData[1]) begin
                toSticky <= 1'b0;
            end
        end
    end

    // Winner is frozen at ARB so later register writes cannot disturb it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            K_IntReq    <= 1'b0;
            K_IntID     <= 1'b0;
            K_IntNum    <= '0;
            inr         <= '0;
            latchedEdge <= 1'b0;
            waitCnt     <= '0;
        end else begin
            K_IntReq <= (state == ST_ARB) && anyReq;
            if ((state == ST_ARB) && anyReq) begin
                if (urgPend) begin
                    K_IntID     <= 1'b1;
                    K_IntNum    <= '0;
                    inr         <= '0;
                    latchedEdge <= 1'b1;
                end else if (winValid) begin
                    K_IntID     <= 1'b0;
                    K_IntNum    <= winNum;
                    inr         <= winNum;
                    latchedEdge <= winEdge;
                end
            end
            if (state == ST_REQ) begin
                waitCnt <= '0;
            end else if (state == ST_WAIT_ACK) begin
                waitCnt <= waitCnt + 16'd1;
            end
        end
    end

    always_comb begin
        RdData = '0;
        case (RegAddress)
            ADDR_IER: RdData[0]           = ier;
            ADDR_IMR: RdData[NUM_IRQ-1:0] = imr;
            ADDR_ITR: RdData[NUM_IRQ-1:0] = itr;
            ADDR_IPR: RdData[NUM_IRQ-1:0] = ipr;
            ADDR_INR: RdData[ID_W-1:0]    = inr;
            ADDR_ISR: RdData[1:0]         = {toSticky, state != ST_IDLE};
            default:  RdData              = '0;
        endcase
    end

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Scoreboard bench for vectored_int_ctrl: stimulus queues expected {ID,Num},
// a monitor pops and compares on every K_IntReq pulse and drives the ack.
module tb_vectored_int_ctrl;

    localparam logic [3:0] A_IER = 4'h0;
    localparam logic [3:0] A_IMR = 4'h1;
    localparam logic [3:0] A_ITR = 4'h2;
    localparam logic [3:0] A_IPR = 4'h3;
    localparam logic [3:0] A_INR = 4'h4;
    localparam logic [3:0] A_ISR = 4'h5;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        WrEn = 1'b0;
    logic        BlockSelect = 1'b0;
    logic [3:0]  RegAddress = 4'h0;
    logic [31:0] WrData = '0;
    logic [31:0] RdData;
    logic        UrgentReq = 1'b0;
    logic [7:0]  IntReq = '0;
    logic        K_IntReq;
    logic        K_IntID;
    logic [2:0]  K_IntNum;
    logic        I_IntAck = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          reqSeen = 0;
    int          lastReqCyc = 0;
    int          drvCyc = 0;
    int          kicksReq = 0;
    int          kicksDone = 0;
    bit          autoAck = 1'b0;
    logic [3:0]  expQ[$];

    vectored_int_ctrl #(
        .NUM_IRQ        (8),
        .ACK_SYNC_STAGES(2),
        .ACK_TIMEOUT    (16)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .WrEn       (WrEn),
        .BlockSelect(BlockSelect),
        .RegAddress (RegAddress),
        .WrData     (WrData),
        .RdData     (RdData),
        .UrgentReq  (UrgentReq),
        .IntReq     (IntReq),
        .K_IntReq   (K_IntReq),
        .K_IntID    (K_IntID),
        .K_IntNum   (K_IntNum),
        .I_IntAck   (I_IntAck)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wrReg(input logic [3:0] a, input logic [31:0] d);
        @(negedge Clock);
        WrEn = 1'b1; BlockSelect = 1'b1; RegAddress = a; WrData = d;
        drvCyc = cyc;
        @(negedge Clock);
        WrEn = 1'b0; BlockSelect = 1'b0; WrData = '0;
    endtask

    task automatic chkReg(input logic [3:0] a, input logic [31:0] e, input string name);
        RegAddress = a;
        #1;
        check(name, RdData, e);
    endtask

    task automatic pulse(input logic [7:0] mask, input logic urg);
        @(negedge Clock);
        IntReq = IntReq | mask; UrgentReq = urg;
        drvCyc = cyc;
        @(negedge Clock);
        IntReq = IntReq & ~mask; UrgentReq = 1'b0;
    endtask

    task automatic waitReq(input int target, input string name);
        int n = 0;
        while (reqSeen < target && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check(name, reqSeen, target);
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    // Monitor: scoreboard compare on every request pulse; sole driver of the ack line.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge Clock);
            if (kicksDone < kicksReq) begin
                I_IntAck = ~I_IntAck;
                kicksDone++;
            end
            if (K_IntReq === 1'b1) begin
                reqSeen++;
                lastReqCyc = cyc;
                if (expQ.size() == 0) begin
                    check("unexpected_req", {28'd0, K_IntID, K_IntNum}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check("req_id_num", {28'd0, K_IntID, K_IntNum}, {28'd0, e});
                end
                if (autoAck) I_IntAck = ~I_IntAck;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset state
        tick(2);
        check("rst_kreq", {31'd0, K_IntReq}, 0);
        check("rst_kid", {31'd0, K_IntID}, 0);
        check("rst_knum", {29'd0, K_IntNum}, 0);
        for (int a = 0; a < 6; a++) chkReg(4'(a), 0, "rst_reg");
        chkReg(4'hA, 0, "rst_unmapped");
        @(negedge Clock);
        Reset = 1'b1;

        wrReg(A_IER, 32'h1);
        wrReg(A_IMR, 32'hFF);
        wrReg(A_ITR, 32'hFF);
        chkReg(A_IMR, 32'hFF, "imr_rw");
        autoAck = 1'b1;

        // Single edge request, latency and ack clear
        expQ.push_back({1'b0, 3'd5});
        pulse(8'h20, 1'b0);
        waitReq(1, "req1_seen");
        check("req_latency", 32'(lastReqCyc - drvCyc), 3);
        r = lastReqCyc;
        waitCyc(r + 5);
        chkReg(A_IPR, 0, "ipr5_cleared_by_ack");
        chkReg(A_INR, 5, "inr5");
        tick(3);
        chkReg(A_ISR, 0, "isr_idle");

        // Urgent beats numbered lines; lowest index first
        expQ.push_back({1'b1, 3'd0});
        expQ.push_back({1'b0, 3'd2});
        expQ.push_back({1'b0, 3'd6});
        pulse(8'h44, 1'b1);
        waitReq(4, "prio_seen");
        tick(10);
        chkReg(A_IPR, 0, "prio_ipr_clear");
        chkReg(A_INR, 6, "inr6");

        // Level line re-requests while held; W1C has no effect on it
        wrReg(A_ITR, 32'hF7);
        @(negedge Clock);
        IntReq[3] = 1'b1;
        repeat (3) expQ.push_back({1'b0, 3'd3});
        waitReq(5, "lvl_req1");
        wrReg(A_IPR, 32'h08);
        chkReg(A_IPR, 32'h08, "lvl_w1c_ignored");
        waitReq(7, "lvl_req3");
        IntReq[3] = 1'b0;
        @(negedge Clock);
        chkReg(A_IPR, 0, "lvl_drop_ipr");
        tick(20);
        check("lvl_no_more_req", reqSeen, 7);

        // Masked line pends silently until unmasked
        wrReg(A_ITR, 32'hFF);
        wrReg(A_IMR, 32'hFD);
        pulse(8'h02, 1'b0);
        tick(5);
        chkReg(A_IPR, 32'h02, "masked_pending");
        check("masked_no_req", reqSeen, 7);
        expQ.push_back({1'b0, 3'd1});
        wrReg(A_IMR, 32'hFF);
        waitReq(8, "unmask_req");
        check("unmask_latency_le3", {31'd0, (lastReqCyc - drvCyc) <= 3}, 1);
        tick(10);

        // Ack timeout leaves pending set and re-requests
        autoAck = 1'b0;
        expQ.push_back({1'b0, 3'd4});
        pulse(8'h10, 1'b0);
        waitReq(9, "to_req");
        r = lastReqCyc;
        waitCyc(r + 17);
        chkReg(A_ISR, 32'h1, "isr_busy_waiting");
        @(negedge Clock);
        chkReg(A_ISR, 32'h2, "isr_timeout");
        chkReg(A_IPR, 32'h10, "ipr_kept_after_timeout");
        autoAck = 1'b1;
        expQ.push_back({1'b0, 3'd4});
        waitReq(10, "to_rereq");
        check("rereq_cycle", 32'(lastReqCyc - r), 20);
        tick(10);
        chkReg(A_ISR, 32'h2, "isr_sticky");
        wrReg(A_ISR, 32'h2);
        chkReg(A_ISR, 0, "isr_w1c");
        chkReg(A_IPR, 0, "ipr_after_rereq_ack");

        // Reset mid-handshake
        autoAck = 1'b0;
        expQ.push_back({1'b0, 3'd7});
        pulse(8'h80, 1'b0);
        waitReq(11, "rst_req");
        tick(3);
        check("pre_rst_knum", {29'd0, K_IntNum}, 7);
        Reset = 1'b0;
        #1;
        check("mid_rst_kreq", {31'd0, K_IntReq}, 0);
        check("mid_rst_kid", {31'd0, K_IntID}, 0);
        check("mid_rst_knum", {29'd0, K_IntNum}, 0);
        chkReg(A_IPR, 0, "mid_rst_ipr");
        chkReg(A_ISR, 0, "mid_rst_isr");
        chkReg(A_IER, 0, "mid_rst_ier");
        tick(2);
        Reset = 1'b1;
        wrReg(A_IER, 32'h1);
        wrReg(A_IMR, 32'hFF);
        wrReg(A_ITR, 32'hFF);
        kicksReq++;
        tick(10);
        chkReg(A_ISR, 0, "post_rst_ack_ignored");
        check("post_rst_no_req", reqSeen, 11);

        autoAck = 1'b1;
        expQ.push_back({1'b0, 3'd7});
        pulse(8'h80, 1'b0);
        waitReq(12, "post_rst_req");
        tick(10);
        chkReg(A_IPR, 0, "post_rst_ipr_clear");
        check("queue_drained", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
